data_mem_arbiter: RTL

//   Two-port round-robin arbiter in front of the single-port data_mem. Shares it between
//   the core load/store unit (port 0) and a debug/DMA master (port 1).

---
 rtl/data_mem_arbiter.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//
// Two-port round-robin arbiter in front of the single-port data_mem. Port 0 is
// the core load/store unit and port 1 is a debug/DMA master. The arbiter
// latches the winning request and drives one memory access. It then returns a
// one-cycle ack that carries the registered read data.
//
// Every access takes three states:
//   IDLE   : wait for a request; the winner's fields are latched at the edge.
//   ACCESS : drive data_mem from the latched fields; a read is captured here.
//   RESP   : pulse the winner's ack. The other port may be latched here, which
//            gives back-to-back service at one access every two cycles.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   mN_req/we/addr/wdata  in   request from port N; held stable until mN_ack
//   mN_ack                out  one-cycle completion pulse for port N
//   mN_rdata              out  read data for port N; zero unless mN_ack=1
//   mem_read/mem_write    out  data_mem strobes; high only during ACCESS
//   mem_addr/mem_wdata    out  data_mem address/data; zero outside ACCESS
//   mem_rdata             in   data_mem combinational read data
//
// Optional feature (macro DMARB_STATS_EN)
//   m0_gnt_cnt/m1_gnt_cnt out  16-bit saturating grant counters, one per port
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic                  m0_ack,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic                  m1_ack,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DMARB_STATS_EN
   ,
   output logic [15:0]           m0_gnt_cnt,
   output logic [15:0]           m1_gnt_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic                  win_q, win_d;     // port being served
   logic                  last_q, last_d;   // port latched most recently
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic                  latch_s;          // a request is latched at this edge
   logic                  lat_port_s;       // which port is latched
   logic                  other_req_s;      // request of the port not being served

   // Next-state, arbitration and request-latch logic
   always_comb begin
      state_d     = state_q;
      win_d       = win_q;
      last_d      = last_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      latch_s     = 1'b0;
      lat_port_s  = 1'b0;
      other_req_s = win_q ? m0_req : m1_req;

      case (state_q)
         ST_IDLE: begin
            if (m0_req || m1_req) begin
               latch_s = 1'b1;
               // A tie goes to the port that did not win last time.
               if (m0_req && m1_req) begin
                  lat_port_s = ~last_q;
               end else begin
                  lat_port_s = m1_req;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            state_d = ST_RESP;
            if (we_q) begin
               rdata_d = {DATA_WIDTH{1'b0}};
            end else begin
               rdata_d = mem_rdata;
            end
         end
         ST_RESP: begin
            // The winner's req is still high during its own ack and is ignored.
            // Only the other port can be latched here.
            if (other_req_s) begin
               latch_s    = 1'b1;
               lat_port_s = ~win_q;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (latch_s) begin
         state_d = ST_ACCESS;
         win_d   = lat_port_s;
         last_d  = lat_port_s;
         we_d    = lat_port_s ? m1_we    : m0_we;
         addr_d  = lat_port_s ? m1_addr  : m0_addr;
         wdata_d = lat_port_s ? m1_wdata : m0_wdata;
      end else begin
         win_d = win_q;
      end
   end

   // State and latched-request registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         win_q   <= 1'b0;
         last_q  <= 1'b1;
         we_q    <= 1'b0;
         addr_q  <= {ADDR_WIDTH{1'b0}};
         wdata_q <= {DATA_WIDTH{1'b0}};
         rdata_q <= {DATA_WIDTH{1'b0}};
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         last_q  <= last_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Output decode from registered state only. An async reset clears the
   // state, so the memory strobes and acks drop the moment rst_n falls.
   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = {ADDR_WIDTH{1'b0}};
      mem_wdata = {DATA_WIDTH{1'b0}};
      m0_ack    = 1'b0;
      m1_ack    = 1'b0;
      m0_rdata  = {DATA_WIDTH{1'b0}};
      m1_rdata  = {DATA_WIDTH{1'b0}};
      if (state_q == ST_ACCESS) begin
         mem_read  = ~we_q;
         mem_write = we_q;
         mem_addr  = addr_q;
         mem_wdata = wdata_q;
      end else if (state_q == ST_RESP) begin
         if (win_q) begin
            m1_ack   = 1'b1;
            m1_rdata = rdata_q;
         end else begin
            m0_ack   = 1'b1;
            m0_rdata = rdata_q;
         end
      end else begin
         mem_read  = 1'b0;
         mem_write = 1'b0;
      end
   end

`ifdef DMARB_STATS_EN
   logic [15:0] m0_gnt_cnt_q, m0_gnt_cnt_d;
   logic [15:0] m1_gnt_cnt_q, m1_gnt_cnt_d;

   // Saturating grant counters, stepped on each latch
   always_comb begin
      m0_gnt_cnt_d = m0_gnt_cnt_q;
      m1_gnt_cnt_d = m1_gnt_cnt_q;
      if (latch_s && !lat_port_s && (m0_gnt_cnt_q != 16'hFFFF)) begin
         m0_gnt_cnt_d = m0_gnt_cnt_q + 16'd1;
      end else begin
         m0_gnt_cnt_d = m0_gnt_cnt_q;
      end
      if (latch_s && lat_port_s && (m1_gnt_cnt_q != 16'hFFFF)) begin
         m1_gnt_cnt_d = m1_gnt_cnt_q + 16'd1;
      end else begin
         m1_gnt_cnt_d = m1_gnt_cnt_q;
      end
   end

   // Grant counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m0_gnt_cnt_q <= 16'd0;
         m1_gnt_cnt_q <= 16'd0;
      end else begin
         m0_gnt_cnt_q <= m0_gnt_cnt_d;
         m1_gnt_cnt_q <= m1_gnt_cnt_d;
      end
   end

   assign m0_gnt_cnt = m0_gnt_cnt_q;
   assign m1_gnt_cnt = m1_gnt_cnt_q;
`endif

endmodule
